// File: rtl/fila_escrita.sv
// fila_escrita: in-order write-request queue between the cluster-filter core
// and the memory write port. Requests are stored as {line address, cluster},
// presented first-word-fall-through and drained over a valid/ready handshake.
// Requests arriving while full are dropped and tallied in a saturating counter.
// Optional feature macro: FILA_DESCARTA_DUPLICADO_EN. When it is defined, a
// request identical to the last accepted one is silently discarded.
module fila_escrita #(
  parameter int PROFUNDIDADE  = 8,
  parameter int TAM_ENDERECO  = 64,
  parameter int NUM_CLUSTERS  = 8,
  parameter int LARG_PERDIDOS = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              entrada_valida,
  input  logic [TAM_ENDERECO-1:0]           endereco,
  input  logic [$clog2(NUM_CLUSTERS)-1:0]   cluster,
  output logic                              cheia,
  output logic                              quase_cheia,
  output logic                              mem_valida,
  output logic [TAM_ENDERECO-1:0]           mem_endereco,
  output logic [$clog2(NUM_CLUSTERS)-1:0]   mem_cluster,
  input  logic                              mem_pronta,
  output logic [$clog2(PROFUNDIDADE):0]     contagem,
  output logic [LARG_PERDIDOS-1:0]          perdidos
);

  localparam int IDX_W   = $clog2(PROFUNDIDADE);
  localparam int PTR_W   = IDX_W + 1;
  localparam int CL_W    = $clog2(NUM_CLUSTERS);
  localparam int LINHA_W = TAM_ENDERECO - 6;
  localparam int ENT_W   = LINHA_W + CL_W;
  localparam logic [PTR_W-1:0] QUASE_LIM = PTR_W'(PROFUNDIDADE - 1);

  // Storage holds only the line part of the address plus the cluster index.
  logic [ENT_W-1:0] mem_q [PROFUNDIDADE];

  logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0]         contagem_q, contagem_d;
  logic                     cheia_q, cheia_d;
  logic                     quase_cheia_q, quase_cheia_d;
  logic [LARG_PERDIDOS-1:0] perdidos_q, perdidos_d;

  logic [ENT_W-1:0] entrada_ent_s;
  logic [ENT_W-1:0] cabeca_s;
  logic             dup_s;
  logic             enq_s;
  logic             deq_s;
  logic             descarte_s;
  logic             unused_baixos_s;

  assign entrada_ent_s   = {endereco[TAM_ENDERECO-1:6], cluster};
  assign unused_baixos_s = ^endereco[5:0];
  assign cabeca_s        = mem_q[rd_q[IDX_W-1:0]];

`ifdef FILA_DESCARTA_DUPLICADO_EN
  logic [ENT_W-1:0] ultimo_q, ultimo_d;
  logic             ultimo_val_q, ultimo_val_d;

  assign dup_s = entrada_valida && ultimo_val_q && (ultimo_q == entrada_ent_s);

  // Remember the most recently accepted request; deq does not clear it.
  always_comb begin
    ultimo_d     = ultimo_q;
    ultimo_val_d = ultimo_val_q;
    if (enq_s) begin
      ultimo_d     = entrada_ent_s;
      ultimo_val_d = 1'b1;
    end else begin
      ultimo_d     = ultimo_q;
      ultimo_val_d = ultimo_val_q;
    end
  end

  // Last-accepted register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ultimo_q     <= '0;
      ultimo_val_q <= 1'b0;
    end else begin
      ultimo_q     <= ultimo_d;
      ultimo_val_q <= ultimo_val_d;
    end
  end
`else
  assign dup_s = 1'b0;
`endif

  // Handshake decode: the full test uses the registered flag, so a deq in the
  // same cycle never frees room for an incoming request.
  always_comb begin
    deq_s      = (contagem_q != '0) && mem_pronta;
    enq_s      = entrada_valida && !dup_s && !cheia_q;
    descarte_s = entrada_valida && !dup_s && cheia_q;
  end

  // Next pointers, occupancy and flags derived purely from pointer arithmetic.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (enq_s) begin
      wr_d = wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (deq_s) begin
      rd_d = rd_q + PTR_W'(1);
    end else begin
      rd_d = rd_q;
    end
    contagem_d    = wr_d - rd_d;
    cheia_d       = (wr_d[IDX_W-1:0] == rd_d[IDX_W-1:0]) && (wr_d[IDX_W] != rd_d[IDX_W]);
    quase_cheia_d = (contagem_d >= QUASE_LIM);
  end

  // Saturating tally of requests lost because the queue was full.
  always_comb begin
    perdidos_d = perdidos_q;
    if (descarte_s && (perdidos_q != '1)) begin
      perdidos_d = perdidos_q + LARG_PERDIDOS'(1);
    end else begin
      perdidos_d = perdidos_q;
    end
  end

  // Control registers; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q          <= '0;
      rd_q          <= '0;
      contagem_q    <= '0;
      cheia_q       <= 1'b0;
      quase_cheia_q <= 1'b0;
      perdidos_q    <= '0;
    end else begin
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      contagem_q    <= contagem_d;
      cheia_q       <= cheia_d;
      quase_cheia_q <= quase_cheia_d;
      perdidos_q    <= perdidos_d;
    end
  end

  // Entry storage; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (rst_n && enq_s) begin
      mem_q[wr_q[IDX_W-1:0]] <= entrada_ent_s;
    end
  end

  // First-word-fall-through view of the head, zeroed when empty.
  always_comb begin
    mem_valida = (contagem_q != '0);
    if (mem_valida) begin
      mem_endereco = {cabeca_s[ENT_W-1:CL_W], 6'b000000};
      mem_cluster  = cabeca_s[CL_W-1:0];
    end else begin
      mem_endereco = '0;
      mem_cluster  = '0;
    end
  end

  assign contagem    = contagem_q;
  assign cheia       = cheia_q;
  assign quase_cheia = quase_cheia_q;
  assign perdidos    = perdidos_q;

endmodule

// File: tb/tb_fila_escrita.sv
// Bench for fila_escrita: directed scenarios plus randomized traffic against a
// queue-based reference model; a negedge monitor scoreboards drained entries.
module tb_fila_escrita;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        entrada_valida;
  logic [63:0] endereco;
  logic [2:0]  cluster;
  logic        cheia, quase_cheia, mem_valida;
  logic [63:0] mem_endereco;
  logic [2:0]  mem_cluster;
  logic        mem_pronta;
  logic [3:0]  contagem;
  logic [7:0]  perdidos;

  int comparados = 0;
  int falhas     = 0;

  // Reference model state
  logic [66:0] modelo[$];
  logic [66:0] esperados[$];
  int          ref_perdidos = 0;
  logic        ult_val = 1'b0;
  logic [66:0] ult_chave = '0;

  fila_escrita dut (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida),
    .endereco(endereco), .cluster(cluster), .cheia(cheia),
    .quase_cheia(quase_cheia), .mem_valida(mem_valida),
    .mem_endereco(mem_endereco), .mem_cluster(mem_cluster),
    .mem_pronta(mem_pronta), .contagem(contagem), .perdidos(perdidos)
  );

  always #5 clk = ~clk;

  task automatic checar(input string nome, input logic [127:0] atual, input logic [127:0] esperado);
    comparados++;
    if (atual !== esperado) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  function automatic logic [66:0] chave(input logic [63:0] a, input logic [2:0] c);
    return {a[63:6], 6'b000000, c};
  endfunction

  // Behavioural rules applied at each rising edge.
  task automatic modelo_atualiza(input logic v, input logic [63:0] a, input logic [2:0] c,
                                 input logic p, input logic r);
    logic cheio, dq, dup, en, drop;
    if (!r) begin
      modelo.delete();
      esperados.delete();
      ref_perdidos = 0;
      ult_val = 1'b0;
    end else begin
      cheio = (modelo.size() == P);
      dq    = (modelo.size() > 0) && p;
`ifdef FILA_DESCARTA_DUPLICADO_EN
      dup   = v && ult_val && (ult_chave == chave(a, c));
`else
      dup   = 1'b0;
`endif
      en    = v && !dup && !cheio;
      drop  = v && !dup && cheio;
      if (dq) void'(modelo.pop_front());
      if (en) begin
        modelo.push_back(chave(a, c));
        esperados.push_back(chave(a, c));
        ult_val   = 1'b1;
        ult_chave = chave(a, c);
      end
      if (drop && ref_perdidos < 255) ref_perdidos++;
    end
  endtask

  // One clock cycle: apply inputs, advance model, check registered status.
  task automatic passo(input logic v, input logic [63:0] a, input logic [2:0] c,
                       input logic p, input logic r);
    entrada_valida = v;
    endereco       = a;
    cluster        = c;
    mem_pronta     = p;
    rst_n          = r;
    @(posedge clk);
    modelo_atualiza(v, a, c, p, r);
    #1;
    checar("contagem", contagem, modelo.size());
    checar("cheia", cheia, modelo.size() == P);
    checar("quase_cheia", quase_cheia, modelo.size() >= P - 1);
    checar("mem_valida", mem_valida, modelo.size() != 0);
    checar("perdidos", perdidos, ref_perdidos);
  endtask

  // Scoreboard monitor: pops expected head on each handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_valida) begin
        if (mem_pronta) begin
          if (esperados.size() == 0) begin
            comparados++;
            falhas++;
            $display("FAIL scoreboard_vazio: got %0h/%0h expected no entry", mem_endereco, mem_cluster);
          end else begin
            checar("saida", {mem_endereco, mem_cluster}, esperados.pop_front());
          end
        end
      end else begin
        checar("saida_vazia", {mem_endereco, mem_cluster}, 67'd0);
      end
    end
  end

  initial begin
    logic [63:0] pool [4];
    logic        r, v, p;
    int          k;

    // 1: reset with requests present
    passo(1'b1, 64'h40, 3'd1, 1'b0, 1'b0);
    passo(1'b1, 64'h80, 3'd2, 1'b0, 1'b0);
    checar("t1_contagem", contagem, 0);
    checar("t1_mem_endereco", mem_endereco, 0);
    checar("t1_mem_cluster", mem_cluster, 0);

    // 2: single enq, one-cycle latency, low bits cleared
    passo(1'b1, 64'h1234_5678_9ABC_DEF7, 3'd5, 1'b0, 1'b1);
    checar("t2_mem_valida", mem_valida, 1);
    checar("t2_mem_endereco", mem_endereco, 64'h1234_5678_9ABC_DEC0);
    checar("t2_mem_cluster", mem_cluster, 5);
    passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);

    // 3: fill past full
    for (int i = 1; i <= 9; i++) begin
      passo(1'b1, 64'h40 * i, 3'(i), 1'b0, 1'b1);
      if (i == 7) checar("t3_quase_7", quase_cheia, 1);
      if (i == 8) checar("t3_cheia_8", cheia, 1);
    end
    checar("t3_perdidos", perdidos, 1);
    for (int i = 0; i < 8; i++) passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);

    // 4: full with simultaneous request and drain
    for (int i = 0; i < 8; i++) passo(1'b1, 64'h1000 + 64'h40 * i, 3'(i), 1'b0, 1'b1);
    passo(1'b1, 64'h8000, 3'd3, 1'b1, 1'b1);
    checar("t4_contagem7", contagem, 7);
    checar("t4_perdidos2", perdidos, 2);
    passo(1'b1, 64'h9000, 3'd4, 1'b1, 1'b1);
    checar("t4_contagem_mantida", contagem, 7);

    // Saturation of the drop counter while full
    passo(1'b1, 64'hA000, 3'd6, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) passo(1'b1, 64'hB000 + 64'h40 * i, 3'd1, 1'b0, 1'b1);
    checar("saturacao", perdidos, 8'hFF);
    for (int i = 0; i < 8; i++) passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);

    // 5: reset mid-drain
    for (int i = 1; i <= 3; i++) passo(1'b1, 64'h2000 + 64'h40 * i, 3'd2, 1'b0, 1'b1);
    passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);
    passo(1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
    checar("t5_contagem", contagem, 0);
    checar("t5_mem_valida", mem_valida, 0);
    passo(1'b1, 64'h80, 3'd7, 1'b0, 1'b1);
    checar("t5_primeiro", mem_endereco, 64'h80);
    passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);

    // 6: duplicate requests
    passo(1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
    passo(1'b1, 64'h100, 3'd2, 1'b0, 1'b1);
    passo(1'b1, 64'h100, 3'd2, 1'b0, 1'b1);
`ifdef FILA_DESCARTA_DUPLICADO_EN
    checar("t6_dup_contagem", contagem, 1);
`else
    checar("t6_dup_contagem", contagem, 2);
`endif
    checar("t6_perdidos", perdidos, 0);
    passo(1'b1, 64'h100, 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);

    // Randomized traffic with a small address pool so repeats occur
    pool[0] = 64'h0000_0000_0000_0140;
    pool[1] = 64'h0000_00FF_0000_0FC0;
    pool[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    pool[3] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 3) != 0);
      p = r && ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 4);
      passo(v, (k < 4) ? (pool[k] ^ 64'($urandom_range(0, 63))) : {$urandom, $urandom},
            3'($urandom_range(0, 7)), p, r);
    end
    for (int i = 0; i < P + 2; i++) passo(1'b0, 64'h0, 3'd0, 1'b1, 1'b1);
    checar("scoreboard_esgotado", esperados.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, falhas);
    $finish;
  end

endmodule
